// File: rtl/lfsr_if.sv
// Handshake and status bundle between an LFSR engine and its user.
`timescale 1ns/1ps
interface lfsr_if #(
   parameter int unsigned WIDTH = 16
);
   logic             en;
   logic             mode;
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_data;
   logic             skip_valid;
   logic             skip_ready;
   logic [15:0]      skip_n;
   logic [WIDTH-1:0] state;
   logic             out_bit;
   logic             busy;
   logic             wrap;
   logic [WIDTH-1:0] period_len;
   logic             lockup;

   modport master (
      output en, mode, load_valid, load_data, skip_valid, skip_n,
      input  load_ready, skip_ready, state, out_bit, busy, wrap, period_len, lockup
   );

   modport slave (
      input  en, mode, load_valid, load_data, skip_valid, skip_n,
      output load_ready, skip_ready, state, out_bit, busy, wrap, period_len, lockup
   );
endinterface

// File: rtl/lfsr_engine.sv
// Fibonacci/Galois LFSR with seed load, zero-seed lock-up protection,
// multi-step skip and period measurement against the loaded seed.
`timescale 1ns/1ps
module lfsr_engine #(
   parameter int unsigned      WIDTH = 16,
   parameter logic [WIDTH-1:0] FTAPS = WIDTH'(16'hB400),
   parameter logic [WIDTH-1:0] GPOLY = WIDTH'(16'h6801),
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(16'h0001)
) (
   input  logic  clk,
   input  logic  rst_n,
   lfsr_if.slave bus
);
   localparam int unsigned SKIP_W = 16;

   typedef enum logic {S_IDLE, S_BUSY} fsm_t;

   fsm_t              r_fsm;
   logic [WIDTH-1:0]  r_state;
   logic [WIDTH-1:0]  r_seed;
   logic [WIDTH-1:0]  r_cnt;
   logic [WIDTH-1:0]  r_period;
   logic [SKIP_W-1:0] r_rem;
   logic              r_wrap;
   logic              r_lockup;

   logic [WIDTH-1:0]  w_fib;
   logic [WIDTH-1:0]  w_gal;
   logic [WIDTH-1:0]  w_next;
   logic [WIDTH-1:0]  w_cnt_inc;
   logic [WIDTH-1:0]  w_load_val;
   logic              w_load_zero;
   logic              w_hit;
   logic              w_step;

   // Next-state candidates; mode is sampled live so it may change between steps.
   always_comb begin
      w_fib       = {r_state[WIDTH-2:0], ^(r_state & FTAPS)};
      w_gal       = {r_state[WIDTH-2:0], 1'b0} ^ (r_state[WIDTH-1] ? GPOLY : '0);
      w_next      = bus.mode ? w_gal : w_fib;
      w_hit       = (w_next == r_seed);
      w_cnt_inc   = r_cnt + WIDTH'(1);
      w_load_zero = (bus.load_data == '0);
      w_load_val  = w_load_zero ? SEED : bus.load_data;
      w_step      = (r_fsm == S_BUSY) ||
                    (bus.en && !bus.load_valid && !bus.skip_valid);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fsm    <= S_IDLE;
         r_state  <= SEED;
         r_seed   <= SEED;
         r_cnt    <= '0;
         r_period <= '0;
         r_rem    <= '0;
         r_wrap   <= 1'b0;
         r_lockup <= 1'b0;
      end else begin
         r_wrap <= 1'b0;
         if (w_step) begin
            r_state <= w_next;
            if (w_hit) begin
               r_wrap   <= 1'b1;
               r_period <= w_cnt_inc;
               r_cnt    <= '0;
            end else begin
               r_cnt <= w_cnt_inc;
            end
         end
         if (r_fsm == S_IDLE) begin
            if (bus.load_valid) begin
               r_state  <= w_load_val;
               r_seed   <= w_load_val;
               r_cnt    <= '0;
               r_lockup <= w_load_zero;
            end else if (bus.skip_valid && (bus.skip_n != '0)) begin
               r_rem <= bus.skip_n;
               r_fsm <= S_BUSY;
            end
         end else begin
            // Leave BUSY on the edge that performs the final step.
            r_rem <= r_rem - SKIP_W'(1);
            if (r_rem == SKIP_W'(1)) r_fsm <= S_IDLE;
         end
      end
   end

   // A simultaneous load wins, so skip is refused in that cycle.
   assign bus.load_ready = (r_fsm == S_IDLE);
   assign bus.skip_ready = (r_fsm == S_IDLE) && !bus.load_valid;
   assign bus.busy       = (r_fsm == S_BUSY);
   assign bus.state      = r_state;
   assign bus.out_bit    = r_state[WIDTH-1];
   assign bus.wrap       = r_wrap;
   assign bus.period_len = r_period;
   assign bus.lockup     = r_lockup;
endmodule

// File: tb/tb_lfsr_engine.sv
// Self-checking bench for lfsr_engine: directed scenarios plus a randomized run
// against an arithmetic reference model.
`timescale 1ns/1ps
module tb_lfsr_engine;
   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   lfsr_if #(.WIDTH(16)) if16 ();
   lfsr_if #(.WIDTH(4))  if4 ();

   lfsr_engine u16 (.clk(clk), .rst_n(rst_n), .bus(if16));
   lfsr_engine #(.WIDTH(4), .FTAPS(4'hC), .GPOLY(4'h3), .SEED(4'h1))
      u4 (.clk(clk), .rst_n(rst_n), .bus(if4));

   always #5 clk = ~clk;

   // Reference model of the 16-bit instance.
   int unsigned m_state, m_seed, m_cnt, m_period, m_rem;
   bit          m_wrap, m_lockup, m_busy;

   function automatic int unsigned ref_step(int unsigned s, bit gal, int unsigned w,
                                            int unsigned taps, int unsigned poly);
      int unsigned mask = (32'd1 << w) - 32'd1;
      int unsigned ones = 0;
      int unsigned r    = (s * 2) & mask;
      if (gal) begin
         if (s >= (mask + 1) / 2) r = r ^ poly;
         return r;
      end
      for (int i = 0; i < int'(w); i++)
         if (((s >> i) & 1) == 1 && ((taps >> i) & 1) == 1) ones++;
      return r | (ones % 2);
   endfunction

   task automatic m_step(input bit gal);
      int unsigned nxt = ref_step(m_state, gal, 16, 32'hB400, 32'h6801);
      m_state = nxt;
      if (nxt == m_seed) begin
         m_wrap   = 1'b1;
         m_period = (m_cnt + 1) & 32'hFFFF;
         m_cnt    = 0;
      end else begin
         m_cnt = (m_cnt + 1) & 32'hFFFF;
      end
   endtask

   // One clock edge; model follows the inputs seen at that edge.
   task automatic cyc16();
      @(posedge clk);
      m_wrap = 1'b0;
      if (!rst_n) begin
         m_state = 1; m_seed = 1; m_cnt = 0; m_period = 0;
         m_lockup = 0; m_busy = 0; m_rem = 0;
      end else if (m_busy) begin
         m_step(if16.mode);
         m_rem--;
         if (m_rem == 0) m_busy = 0;
      end else if (if16.load_valid) begin
         if (if16.load_data == 16'h0) begin
            m_state = 1; m_lockup = 1;
         end else begin
            m_state = if16.load_data; m_lockup = 0;
         end
         m_seed = m_state;
         m_cnt  = 0;
      end else if (if16.skip_valid) begin
         if (if16.skip_n != 16'h0) begin
            m_busy = 1; m_rem = if16.skip_n;
         end
      end else if (if16.en) begin
         m_step(if16.mode);
      end
      #1;
   endtask

   task automatic idle16();
      if16.en = 0; if16.mode = 0; if16.load_valid = 0; if16.load_data = '0;
      if16.skip_valid = 0; if16.skip_n = '0;
   endtask

   task automatic load16(input logic [15:0] d);
      idle16();
      if16.load_valid = 1; if16.load_data = d;
      cyc16();
      idle16();
   endtask

   task automatic test_reset();
      idle16();
      rst_n = 0;
      cyc16();
      cyc16();
      checks++; if (if16.state !== 16'h0001) begin errors++; $display("FAIL reset_state: got %h want 0001", if16.state); end
      checks++; if (if16.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", if16.busy); end
      checks++; if (if16.load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready: got %b want 1", if16.load_ready); end
      checks++; if (if16.skip_ready !== 1'b1) begin errors++; $display("FAIL reset_skip_ready: got %b want 1", if16.skip_ready); end
      checks++; if (if16.wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b want 0", if16.wrap); end
      checks++; if (if16.period_len !== 16'h0) begin errors++; $display("FAIL reset_period: got %h want 0000", if16.period_len); end
      checks++; if (if16.lockup !== 1'b0) begin errors++; $display("FAIL reset_lockup: got %b want 0", if16.lockup); end
      checks++; if (if4.state !== 4'h1) begin errors++; $display("FAIL reset_state4: got %h want 1", if4.state); end
      rst_n = 1;
   endtask

   task automatic test_fibonacci();
      load16(16'h0001);
      if16.mode = 0; if16.en = 1;
      for (int k = 1; k <= 11; k++) begin
         cyc16();
         checks++; if (if16.state !== 16'(m_state)) begin errors++; $display("FAIL fib_model step %0d: got %h want %h", k, if16.state, 16'(m_state)); end
         if (k == 10) begin
            checks++; if (if16.state !== 16'h0400) begin errors++; $display("FAIL fib_step10: got %h want 0400", if16.state); end
         end
      end
      checks++; if (if16.state !== 16'h0801) begin errors++; $display("FAIL fib_step11: got %h want 0801", if16.state); end
      idle16();
   endtask

   task automatic test_galois();
      load16(16'h8000);
      checks++; if (if16.out_bit !== 1'b1) begin errors++; $display("FAIL gal_out_bit_before: got %b want 1", if16.out_bit); end
      if16.mode = 1; if16.en = 1;
      cyc16();
      idle16();
      checks++; if (if16.state !== 16'h6801) begin errors++; $display("FAIL gal_step: got %h want 6801", if16.state); end
      checks++; if (if16.out_bit !== 1'b0) begin errors++; $display("FAIL gal_out_bit_after: got %b want 0", if16.out_bit); end
   endtask

   task automatic test_skip();
      int busy_cycles = 0;
      int guard = 0;
      load16(16'h0001);
      if16.skip_valid = 1; if16.skip_n = 16'd11;
      #1;
      checks++; if (if16.skip_ready !== 1'b1) begin errors++; $display("FAIL skip_ready_idle: got %b want 1", if16.skip_ready); end
      cyc16();
      idle16();
      checks++; if (if16.load_ready !== 1'b0) begin errors++; $display("FAIL skip_load_ready_busy: got %b want 0", if16.load_ready); end
      while (if16.busy === 1'b1 && guard < 40) begin
         busy_cycles++;
         if16.en = 1'($urandom);
         cyc16();
         guard++;
      end
      idle16();
      checks++; if (busy_cycles != 11) begin errors++; $display("FAIL skip_busy_cycles: got %0d want 11", busy_cycles); end
      checks++; if (if16.state !== 16'h0801) begin errors++; $display("FAIL skip_state: got %h want 0801", if16.state); end
      checks++; if (if16.skip_ready !== 1'b1) begin errors++; $display("FAIL skip_ready_after: got %b want 1", if16.skip_ready); end
   endtask

   task automatic test_lockup_priority();
      load16(16'h0000);
      checks++; if (if16.state !== 16'h0001) begin errors++; $display("FAIL lockup_state: got %h want 0001", if16.state); end
      checks++; if (if16.lockup !== 1'b1) begin errors++; $display("FAIL lockup_flag: got %b want 1", if16.lockup); end
      if16.load_valid = 1; if16.load_data = 16'h1234;
      if16.skip_valid = 1; if16.skip_n = 16'd5; if16.en = 1;
      #1;
      checks++; if (if16.skip_ready !== 1'b0) begin errors++; $display("FAIL prio_skip_ready: got %b want 0", if16.skip_ready); end
      checks++; if (if16.load_ready !== 1'b1) begin errors++; $display("FAIL prio_load_ready: got %b want 1", if16.load_ready); end
      cyc16();
      idle16();
      checks++; if (if16.state !== 16'h1234) begin errors++; $display("FAIL prio_state: got %h want 1234", if16.state); end
      checks++; if (if16.busy !== 1'b0) begin errors++; $display("FAIL prio_busy: got %b want 0", if16.busy); end
      checks++; if (if16.lockup !== 1'b0) begin errors++; $display("FAIL prio_lockup: got %b want 0", if16.lockup); end
      cyc16();
      checks++; if (if16.state !== 16'h1234) begin errors++; $display("FAIL prio_no_skip: got %h want 1234", if16.state); end
   endtask

   task automatic test_reset_mid_skip();
      idle16();
      if16.skip_valid = 1; if16.skip_n = 16'd100;
      cyc16();
      idle16();
      repeat (5) cyc16();
      checks++; if (if16.busy !== 1'b1) begin errors++; $display("FAIL midskip_busy: got %b want 1", if16.busy); end
      rst_n = 0;
      cyc16();
      rst_n = 1;
      checks++; if (if16.busy !== 1'b0) begin errors++; $display("FAIL midskip_rst_busy: got %b want 0", if16.busy); end
      checks++; if (if16.state !== 16'h0001) begin errors++; $display("FAIL midskip_rst_state: got %h want 0001", if16.state); end
      checks++; if (if16.period_len !== 16'h0) begin errors++; $display("FAIL midskip_rst_period: got %h want 0000", if16.period_len); end
      checks++; if (if16.skip_ready !== 1'b1) begin errors++; $display("FAIL midskip_rst_ready: got %b want 1", if16.skip_ready); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         if16.en         = 1'($urandom);
         if16.mode       = 1'($urandom);
         if16.load_valid = ($urandom_range(0, 15) == 0);
         if16.load_data  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
         if16.skip_valid = ($urandom_range(0, 9) == 0);
         if16.skip_n     = 16'($urandom_range(0, 12));
         #1;
         checks++; if (if16.skip_ready !== (!m_busy && !if16.load_valid)) begin errors++; $display("FAIL rnd_skip_ready cyc %0d: got %b want %b", k, if16.skip_ready, (!m_busy && !if16.load_valid)); end
         cyc16();
         checks++; if (if16.state !== 16'(m_state)) begin errors++; $display("FAIL rnd_state cyc %0d: got %h want %h", k, if16.state, 16'(m_state)); end
         checks++; if (if16.busy !== m_busy) begin errors++; $display("FAIL rnd_busy cyc %0d: got %b want %b", k, if16.busy, m_busy); end
         checks++; if (if16.wrap !== m_wrap) begin errors++; $display("FAIL rnd_wrap cyc %0d: got %b want %b", k, if16.wrap, m_wrap); end
         checks++; if (if16.period_len !== 16'(m_period)) begin errors++; $display("FAIL rnd_period cyc %0d: got %h want %h", k, if16.period_len, 16'(m_period)); end
         checks++; if (if16.lockup !== m_lockup) begin errors++; $display("FAIL rnd_lockup cyc %0d: got %b want %b", k, if16.lockup, m_lockup); end
      end
      idle16();
      while (m_busy) cyc16();
   endtask

   task automatic test_period4();
      int wraps = 0;
      idle16();
      rst_n = 0;
      cyc16();
      rst_n = 1;
      if4.en = 1; if4.mode = 0;
      for (int k = 1; k <= 45; k++) begin
         cyc16();
         if (if4.wrap === 1'b1) wraps++;
         checks++; if (if4.wrap !== (k % 15 == 0)) begin errors++; $display("FAIL p4_wrap step %0d: got %b want %b", k, if4.wrap, (k % 15 == 0)); end
      end
      if4.en = 0;
      checks++; if (wraps != 3) begin errors++; $display("FAIL p4_wrap_count: got %0d want 3", wraps); end
      checks++; if (if4.period_len !== 4'hF) begin errors++; $display("FAIL p4_period: got %h want f", if4.period_len); end
   endtask

   task automatic test_period16();
      int wraps = 0;
      int wrap_at = 0;
      idle16();
      rst_n = 0;
      cyc16();
      rst_n = 1;
      if16.en = 1;
      for (int k = 1; k <= 65535; k++) begin
         cyc16();
         if (if16.wrap === 1'b1) begin wraps++; wrap_at = k; end
      end
      idle16();
      checks++; if (wraps != 1) begin errors++; $display("FAIL p16_wrap_count: got %0d want 1", wraps); end
      checks++; if (wrap_at != 65535) begin errors++; $display("FAIL p16_wrap_at: got %0d want 65535", wrap_at); end
      checks++; if (if16.period_len !== 16'hFFFF) begin errors++; $display("FAIL p16_period: got %h want ffff", if16.period_len); end
      checks++; if (if16.state !== 16'h0001) begin errors++; $display("FAIL p16_state: got %h want 0001", if16.state); end
   endtask

   initial begin
      rst_n = 0;
      idle16();
      if4.en = 0; if4.mode = 0; if4.load_valid = 0; if4.load_data = '0;
      if4.skip_valid = 0; if4.skip_n = '0;
      test_reset();
      test_fibonacci();
      test_galois();
      test_skip();
      test_lockup_priority();
      test_reset_mid_skip();
      test_random();
      test_period4();
      test_period16();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
